cci_mpf_shim_rd_throttle: RTL and testbench

//   AFU-side shim that sits directly upstream of the MPF wrapper. It caps the number of

---
 rtl/cci_mpf_throttle_pkg.sv | 23 ++
 rtl/cci_mpf_shim_rd_throttle_if.sv | 30 +++
 rtl/cci_mpf_throttle_fifo.sv | 64 ++++++
 rtl/cci_mpf_shim_rd_throttle.sv | 128 ++++++++++++
 tb/tb_cci_mpf_shim_rd_throttle.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/cci_mpf_throttle_pkg.sv
// Shared types and defaults for the c0 read throttle shim.
//   t_throttle_state : issue FSM states
//   credit_cnt_width : width needed to hold 0..MAX_OUTSTANDING
//   DEF_*            : default parameter values
package cci_mpf_throttle_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // FIFO empty, nothing to issue
    ISSUE   = 2'd1,  // FIFO holds requests and nothing is blocking
    BLOCKED = 2'd2   // MPF almost-full or credits exhausted
  } t_throttle_state;

  localparam int DEF_REQ_WIDTH       = 64;
  localparam int DEF_RSP_WIDTH       = 528;
  localparam int DEF_MAX_OUTSTANDING = 128;
  localparam int DEF_FIFO_DEPTH      = 16;
  localparam int DEF_ALMFULL_SLACK   = 8;

  function automatic int credit_cnt_width(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/cci_mpf_shim_rd_throttle_if.sv
// c0 read channel bundle between AFU, throttle shim and MPF.
//   slave  : the shim's view (takes AFU requests and MPF responses)
//   master : the environment's view (AFU + MPF side)
interface cci_mpf_shim_rd_throttle_if
  import cci_mpf_throttle_pkg::*;
#(
  parameter int REQ_WIDTH = DEF_REQ_WIDTH,
  parameter int RSP_WIDTH = DEF_RSP_WIDTH
);
  logic                 afu_c0_req_valid;
  logic [REQ_WIDTH-1:0] afu_c0_req;
  logic                 afu_c0_almfull;
  logic                 mpf_c0_req_valid;
  logic [REQ_WIDTH-1:0] mpf_c0_req;
  logic                 mpf_c0_almfull;
  logic                 mpf_c0_rsp_valid;
  logic [RSP_WIDTH-1:0] mpf_c0_rsp;
  logic                 afu_c0_rsp_valid;
  logic [RSP_WIDTH-1:0] afu_c0_rsp;

  modport slave (
    input  afu_c0_req_valid, afu_c0_req, mpf_c0_almfull, mpf_c0_rsp_valid, mpf_c0_rsp,
    output afu_c0_almfull, mpf_c0_req_valid, mpf_c0_req, afu_c0_rsp_valid, afu_c0_rsp
  );

  modport master (
    output afu_c0_req_valid, afu_c0_req, mpf_c0_almfull, mpf_c0_rsp_valid, mpf_c0_rsp,
    input  afu_c0_almfull, mpf_c0_req_valid, mpf_c0_req, afu_c0_rsp_valid, afu_c0_rsp
  );
endinterface

// File: rtl/cci_mpf_throttle_fifo.sv
// Skid FIFO for read request headers (LUTRAM storage, asynchronous head read).
//   clk, reset   : clock, synchronous active-high reset
//   enq_i        : write enq_data_i (dropped if full)
//   deq_i        : pop the head (ignored if empty)
//   deq_data_o   : current head entry
//   count_next_o : occupancy after this cycle's enqueue/dequeue
//   empty_o      : no entries held
module cci_mpf_throttle_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_i,
  input  logic [WIDTH-1:0]         enq_data_i,
  input  logic                     deq_i,
  output logic [WIDTH-1:0]         deq_data_o,
  output logic [$clog2(DEPTH):0]   count_next_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full, do_enq, do_deq;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_enq  = enq_i && !full;
  assign do_deq  = deq_i && !empty_o;
  assign count_d = count_q + CW'(do_enq) - CW'(do_deq);

  assign deq_data_o   = mem_q[rd_ptr_q];
  assign count_next_o = count_d;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
      if (do_enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_deq) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // NOTE: storage has no reset; the count and pointers alone define which
  // entries are valid, and a reset port would stop LUTRAM mapping.
  always_ff @(posedge clk) begin
    if (do_enq) mem_q[wr_ptr_q] <= enq_data_i;
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(enq_i && full))
    else $error("read request written into a full throttle FIFO; request dropped");
`endif

endmodule

// File: rtl/cci_mpf_shim_rd_throttle.sv
// Caps outstanding c0 reads into MPF at MAX_OUTSTANDING. AFU requests land in a
// skid FIFO (almost-full back-pressure), issue one per cycle while credits and MPF
// allow, and each in-order MPF response is forwarded (1 cycle) and returns a credit.
//   clk, reset   : clock, synchronous active-high reset
//   bus          : c0 request/response channel (slave modport)
//   rd_in_flight : reads issued to MPF and not yet answered
//   stall_cycles : saturating count of cycles with queued requests but no issue
module cci_mpf_shim_rd_throttle
  import cci_mpf_throttle_pkg::*;
#(
  parameter int REQ_WIDTH       = DEF_REQ_WIDTH,
  parameter int RSP_WIDTH       = DEF_RSP_WIDTH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int ALMFULL_SLACK   = DEF_ALMFULL_SLACK
) (
  input  logic                                          clk,
  input  logic                                          reset,
  cci_mpf_shim_rd_throttle_if.slave                     bus,
  output logic [credit_cnt_width(MAX_OUTSTANDING)-1:0]  rd_in_flight,
  output logic [31:0]                                   stall_cycles
);
  localparam int IFW   = credit_cnt_width(MAX_OUTSTANDING);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [REQ_WIDTH-1:0] fifo_head;
  logic [CNT_W-1:0]     fifo_count_d;
  logic                 fifo_empty;

  t_throttle_state      state_q;
  logic                 pop, drained_next, blocked_next;
  logic [IFW-1:0]       in_flight_q, in_flight_d;
  logic [31:0]          stall_q, stall_d;
  logic                 almfull_q, req_valid_q, rsp_valid_q;
  logic [REQ_WIDTH-1:0] req_q;
  logic [RSP_WIDTH-1:0] rsp_q;

  cci_mpf_throttle_fifo #(.WIDTH(REQ_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .enq_i        (bus.afu_c0_req_valid),
    .enq_data_i   (bus.afu_c0_req),
    .deq_i        (pop),
    .deq_data_o   (fifo_head),
    .count_next_o (fifo_count_d),
    .empty_o      (fifo_empty)
  );

  // The FSM state is a registered summary; the live almfull and credit terms
  // are re-checked here so a release takes effect in the same cycle.
  assign pop = (state_q != IDLE) && !fifo_empty && !bus.mpf_c0_almfull &&
               (in_flight_q < IFW'(MAX_OUTSTANDING));

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    in_flight_d = in_flight_q;
    if (pop && !bus.mpf_c0_rsp_valid) begin
      in_flight_d = in_flight_q + IFW'(1);
    end else if (!pop && bus.mpf_c0_rsp_valid && in_flight_q != '0) begin
      // A response with nothing in flight is stale (pre-reset): hold at 0.
      in_flight_d = in_flight_q - IFW'(1);
    end

    stall_d = stall_q;
    if (!fifo_empty && !pop && stall_q != '1) stall_d = stall_q + 32'd1;
  end

  assign drained_next = (fifo_count_d == '0);
  assign blocked_next = bus.mpf_c0_almfull || (in_flight_d >= IFW'(MAX_OUTSTANDING));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (!drained_next) state_q <= blocked_next ? BLOCKED : ISSUE;
        ISSUE:   if (drained_next) state_q <= IDLE;
                 else if (blocked_next) state_q <= BLOCKED;
        BLOCKED: if (drained_next) state_q <= IDLE;
                 else if (!blocked_next) state_q <= ISSUE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      almfull_q   <= 1'b1;
      req_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      in_flight_q <= '0;
      stall_q     <= '0;
    end else begin
      almfull_q   <= (fifo_count_d >= CNT_W'(FIFO_DEPTH - ALMFULL_SLACK));
      req_valid_q <= pop;
      rsp_valid_q <= bus.mpf_c0_rsp_valid;
      in_flight_q <= in_flight_d;
      stall_q     <= stall_d;
    end
  end

  // Payload registers are qualified by their valids and need no reset.
  always_ff @(posedge clk) begin
    if (pop) req_q <= fifo_head;
    rsp_q <= bus.mpf_c0_rsp;
  end

  assign bus.afu_c0_almfull   = almfull_q;
  assign bus.mpf_c0_req_valid = req_valid_q;
  assign bus.mpf_c0_req       = req_q;
  assign bus.afu_c0_rsp_valid = rsp_valid_q;
  assign bus.afu_c0_rsp       = rsp_q;
  assign rd_in_flight         = in_flight_q;
  assign stall_cycles         = stall_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && bus.mpf_c0_rsp_valid && in_flight_q == '0)
      $warning("stale c0 read response with no reads in flight; forwarded");
  end

  a_credit_cap: assert property (@(posedge clk) disable iff (reset)
    in_flight_q <= IFW'(MAX_OUTSTANDING))
    else $error("rd_in_flight above MAX_OUTSTANDING");
`endif

endmodule

// File: tb/tb_cci_mpf_shim_rd_throttle.sv
module tb_cci_mpf_shim_rd_throttle;
  localparam int RQW   = 64;
  localparam int RSW   = 528;
  localparam int MAXO  = 4;
  localparam int DEPTH = 16;
  localparam int SLACK = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  rd_in_flight;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  cci_mpf_shim_rd_throttle_if #(.REQ_WIDTH(RQW), .RSP_WIDTH(RSW)) bus ();

  cci_mpf_shim_rd_throttle #(
    .REQ_WIDTH(RQW), .RSP_WIDTH(RSW), .MAX_OUTSTANDING(MAXO),
    .FIFO_DEPTH(DEPTH), .ALMFULL_SLACK(SLACK)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .rd_in_flight (rd_in_flight),
    .stall_cycles (stall_cycles)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [RSW-1:0] act, input logic [RSW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RQW-1:0] hdr(input logic [7:0] t);
    return {56'hC0FFEE00000000, t};
  endfunction

  // Reference model: a queue of pending headers plus plain counters.
  logic [RQW-1:0] m_q [$];
  int             m_if = 0;
  logic [31:0]    m_stall = '0;
  logic           m_alm = 1'b1, m_mv = 1'b0, m_rv = 1'b0;
  logic [RQW-1:0] m_req = '0;
  logic [RSW-1:0] m_rsp = '0;

  logic [RQW-1:0] obs [$];
  int             obs_cyc [$];
  int             cyc = 0;
  bit             auto_rsp = 1'b0;

  task automatic step(input logic rst, input logic enq, input logic [RQW-1:0] h,
                      input logic malm, input logic rspv, input logic [RSW-1:0] rsp);
    bit pop, full;
    if (auto_rsp) rspv = bus.mpf_c0_req_valid;
    reset                = rst;
    bus.afu_c0_req_valid = enq;
    bus.afu_c0_req       = h;
    bus.mpf_c0_almfull   = malm;
    bus.mpf_c0_rsp_valid = rspv;
    bus.mpf_c0_rsp       = rsp;

    if (rst) begin
      m_q.delete();
      m_if = 0; m_stall = '0; m_alm = 1'b1; m_mv = 1'b0; m_rv = 1'b0;
    end else begin
      full = (m_q.size() == DEPTH);
      pop  = (m_q.size() > 0) && !malm && (m_if < MAXO);
      if (m_q.size() > 0 && !pop && m_stall != 32'hFFFF_FFFF) m_stall++;
      m_mv = pop;
      if (pop) m_req = m_q.pop_front();
      if (enq && !full) m_q.push_back(h);
      if (pop && !rspv) m_if++;
      else if (rspv && !pop && m_if > 0) m_if--;
      m_alm = (m_q.size() >= DEPTH - SLACK);
      m_rv  = rspv;
      m_rsp = rsp;
    end

    @(posedge clk);
    #1;
    cyc++;
    check("m_almfull", RSW'(bus.afu_c0_almfull), RSW'(m_alm));
    check("m_req_valid", RSW'(bus.mpf_c0_req_valid), RSW'(m_mv));
    if (m_mv) check("m_req", RSW'(bus.mpf_c0_req), RSW'(m_req));
    check("m_in_flight", RSW'(rd_in_flight), RSW'(m_if));
    check("m_rsp_valid", RSW'(bus.afu_c0_rsp_valid), RSW'(m_rv));
    if (m_rv) check("m_rsp", bus.afu_c0_rsp, m_rsp);
    check("m_stall", RSW'(stall_cycles), RSW'(m_stall));
    if (bus.mpf_c0_req_valid) begin
      obs.push_back(bus.mpf_c0_req);
      obs_cyc.push_back(cyc);
    end
  endtask

  task automatic idle(input int n, input logic malm);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, malm, 1'b0, '0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  typedef struct {
    logic       rst, enq, malm, rspv;
    logic [7:0] tag;      // enqueued header tag, or response payload
    logic       e_alm, e_mv;
    logic [7:0] e_tag;    // expected issued header tag when e_mv
    int         e_if;
    logic       e_rv;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic enq, input logic malm,
                              input logic rspv, input logic [7:0] tag, input logic e_alm,
                              input logic e_mv, input logic [7:0] e_tag, input int e_if,
                              input logic e_rv);
    vec_t v;
    v.rst = rst; v.enq = enq; v.malm = malm; v.rspv = rspv; v.tag = tag;
    v.e_alm = e_alm; v.e_mv = e_mv; v.e_tag = e_tag; v.e_if = e_if; v.e_rv = e_rv;
    return v;
  endfunction

  localparam int NV = 22;
  vec_t tbl [NV];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_prev;
    // Reset, single request/response, then simultaneous issue + response at 3 in flight.
    for (int i = 0; i < 5; i++) tbl[i] = mk(1, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    tbl[7]  = mk(0, 1, 0, 0, 8'hA1, 0, 0, 8'h00, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 8'h00, 0, 1, 8'hA1, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    tbl[10] = mk(0, 0, 0, 1, 8'h51, 0, 0, 8'h00, 0, 1);
    tbl[11] = mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    tbl[12] = mk(0, 1, 0, 0, 8'hB1, 0, 0, 8'h00, 0, 0);
    tbl[13] = mk(0, 1, 0, 0, 8'hB2, 0, 1, 8'hB1, 1, 0);
    tbl[14] = mk(0, 1, 0, 0, 8'hB3, 0, 1, 8'hB2, 2, 0);
    tbl[15] = mk(0, 1, 0, 0, 8'hB4, 0, 1, 8'hB3, 3, 0);
    tbl[16] = mk(0, 0, 0, 1, 8'h52, 0, 1, 8'hB4, 3, 1);
    tbl[17] = mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 3, 0);
    tbl[18] = mk(0, 0, 0, 1, 8'h53, 0, 0, 8'h00, 2, 1);
    tbl[19] = mk(0, 0, 0, 1, 8'h54, 0, 0, 8'h00, 1, 1);
    tbl[20] = mk(0, 0, 0, 1, 8'h55, 0, 0, 8'h00, 0, 1);
    tbl[21] = mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].rst, tbl[i].enq, hdr(tbl[i].tag), tbl[i].malm, tbl[i].rspv, RSW'(tbl[i].tag));
      check($sformatf("v%0d_almfull", i), RSW'(bus.afu_c0_almfull), RSW'(tbl[i].e_alm));
      check($sformatf("v%0d_req_valid", i), RSW'(bus.mpf_c0_req_valid), RSW'(tbl[i].e_mv));
      if (tbl[i].e_mv) check($sformatf("v%0d_req", i), RSW'(bus.mpf_c0_req), RSW'(hdr(tbl[i].e_tag)));
      check($sformatf("v%0d_in_flight", i), RSW'(rd_in_flight), RSW'(tbl[i].e_if));
      check($sformatf("v%0d_rsp_valid", i), RSW'(bus.afu_c0_rsp_valid), RSW'(tbl[i].e_rv));
      if (tbl[i].e_rv) check($sformatf("v%0d_rsp", i), bus.afu_c0_rsp, RSW'(tbl[i].tag));
    end

    // Credit cap: 6 back-to-back requests, only MAXO issue.
    do_reset(2); idle(1, 1'b0);
    obs.delete(); obs_cyc.delete();
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, hdr(8'(8'h30 + k)), 1'b0, 1'b0, '0);
    s_prev = int'(stall_cycles);
    for (int k = 0; k < 3; k++) begin
      idle(1, 1'b0);
      check("cap_stall_step", RSW'(int'(stall_cycles) - s_prev), RSW'(1));
      s_prev = int'(stall_cycles);
    end
    check("cap_issued", RSW'(obs.size()), RSW'(MAXO));
    for (int k = 0; k < obs.size(); k++) check("cap_order", RSW'(obs[k]), RSW'(hdr(8'(8'h30 + k))));
    check("cap_in_flight", RSW'(rd_in_flight), RSW'(MAXO));
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, RSW'(32'h1234));
    check("cap_rsp_credit", RSW'(rd_in_flight), RSW'(MAXO - 1));
    idle(1, 1'b0);
    check("cap_5th_valid", RSW'(bus.mpf_c0_req_valid), RSW'(1));
    check("cap_5th_hdr", RSW'(bus.mpf_c0_req), RSW'(hdr(8'h34)));

    // MPF almost-full: 12 queued, almfull at count 8, then 12 consecutive issues.
    do_reset(2); idle(1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b1, hdr(8'(8'h40 + k)), 1'b1, 1'b0, '0);
      check($sformatf("alm_after_%0d", k + 1), RSW'(bus.afu_c0_almfull), RSW'(k + 1 >= DEPTH - SLACK));
    end
    check("alm_none_issued", RSW'(bus.mpf_c0_req_valid), RSW'(0));
    obs.delete(); obs_cyc.delete();
    auto_rsp = 1'b1;
    idle(14, 1'b0);
    auto_rsp = 1'b0;
    check("alm_issue_cnt", RSW'(obs.size()), RSW'(12));
    for (int k = 0; k < obs.size(); k++) begin
      check($sformatf("alm_hdr_%0d", k), RSW'(obs[k]), RSW'(hdr(8'(8'h40 + k))));
      check($sformatf("alm_cyc_%0d", k), RSW'(obs_cyc[k] - obs_cyc[0]), RSW'(k));
    end

    // Reset with 3 in flight and 2 queued, then a stale response.
    do_reset(2); idle(1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, hdr(8'(8'h60 + k)), 1'b0, 1'b0, '0);
    idle(1, 1'b0);
    step(1'b0, 1'b1, hdr(8'h63), 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, hdr(8'h64), 1'b1, 1'b0, '0);
    check("rst_pre_in_flight", RSW'(rd_in_flight), RSW'(3));
    do_reset(2);
    obs.delete(); obs_cyc.delete();
    idle(3, 1'b0);
    check("rst_fifo_empty", RSW'(obs.size()), RSW'(0));
    check("rst_in_flight", RSW'(rd_in_flight), RSW'(0));
    check("rst_stall", RSW'(stall_cycles), RSW'(0));
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, RSW'(32'hDEAD));
    check("stale_rsp_valid", RSW'(bus.afu_c0_rsp_valid), RSW'(1));
    check("stale_rsp", bus.afu_c0_rsp, RSW'(32'hDEAD));
    check("stale_in_flight", RSW'(rd_in_flight), RSW'(0));

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      bit e, malm, r;
      e    = !bus.afu_c0_almfull && ($urandom_range(1, 0) == 1);
      malm = ($urandom_range(3, 0) == 0);
      r    = (m_if > 0) && ($urandom_range(2, 0) == 0);
      step(1'b0, e, {$urandom, $urandom}, malm, r, RSW'({$urandom, $urandom}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
